// File: rtl/bus_master.sv
// CPU-to-bus master: accepts one load/store, drives a single-cycle bus issue,
// waits for the responder on loads (with timeout) and returns a one-cycle response.
module bus_master #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_en,
  output logic        bus_write_enable,
  output logic        bus_byte_select,
  output logic        bus_byte_enable,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_data_out,
  input  logic [15:0] bus_data_in,
  input  logic        bus_serviced_read
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_is_write, w_is_write_next;
  logic        r_is_byte, w_is_byte_next;
  logic        r_req_ready, w_req_ready_next;
  logic        r_resp_valid, w_resp_valid_next;
  logic [15:0] r_resp_rdata, w_resp_rdata_next;
  logic        r_resp_err, w_resp_err_next;
  logic        r_bus_en, w_bus_en_next;
  logic        r_bus_we, w_bus_we_next;
  logic        r_bus_bs, w_bus_bs_next;
  logic        r_bus_be, w_bus_be_next;
  logic [15:0] r_bus_addr, w_bus_addr_next;
  logic [15:0] r_bus_dout, w_bus_dout_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_is_write   <= 1'b0;
      r_is_byte    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 16'h0000;
      r_resp_err   <= 1'b0;
      r_bus_en     <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_bs     <= 1'b0;
      r_bus_be     <= 1'b0;
      r_bus_addr   <= 16'h0000;
      r_bus_dout   <= 16'h0000;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_is_write   <= w_is_write_next;
      r_is_byte    <= w_is_byte_next;
      r_req_ready  <= w_req_ready_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_rdata <= w_resp_rdata_next;
      r_resp_err   <= w_resp_err_next;
      r_bus_en     <= w_bus_en_next;
      r_bus_we     <= w_bus_we_next;
      r_bus_bs     <= w_bus_bs_next;
      r_bus_be     <= w_bus_be_next;
      r_bus_addr   <= w_bus_addr_next;
      r_bus_dout   <= w_bus_dout_next;
    end
  end

  // Every output is computed from the state being entered, so the registered
  // value lines up with the cycle spent in that state.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_is_write_next   = r_is_write;
    w_is_byte_next    = r_is_byte;
    w_req_ready_next  = 1'b0;
    w_resp_valid_next = 1'b0;
    w_resp_rdata_next = r_resp_rdata;
    w_resp_err_next   = r_resp_err;
    w_bus_en_next     = 1'b0;
    w_bus_we_next     = 1'b0;
    w_bus_bs_next     = 1'b0;
    w_bus_be_next     = 1'b0;
    w_bus_addr_next   = r_bus_addr;
    w_bus_dout_next   = r_bus_dout;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_next    = S_ISSUE;
          w_is_write_next = req_write;
          w_is_byte_next  = req_byte;
          w_bus_en_next   = 1'b1;
          w_bus_we_next   = req_write;
          w_bus_be_next   = req_byte;
          w_bus_bs_next   = req_addr[0];
          w_bus_addr_next = {1'b0, req_addr[15:1]};
          w_bus_dout_next = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
        end else begin
          w_req_ready_next = 1'b1;
        end
      end
      S_ISSUE: begin
        // A serviced_read seen here belongs to an earlier access and is dropped.
        if (r_is_write) begin
          w_state_next      = S_RESP;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = 16'h0000;
          w_resp_err_next   = 1'b0;
        end else begin
          w_state_next = S_WAIT;
          w_cnt_next   = 8'd0;
        end
      end
      S_WAIT: begin
        if (bus_serviced_read) begin
          w_state_next      = S_RESP;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = r_is_byte ? {8'h00, bus_data_in[7:0]} : bus_data_in;
          w_resp_err_next   = 1'b0;
        end else if (r_cnt == LP_LAST_WAIT) begin
          w_state_next      = S_RESP;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = 16'h0000;
          w_resp_err_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_state_next     = S_IDLE;
        w_req_ready_next = 1'b1;
      end
      default: begin
        w_state_next     = S_IDLE;
        w_req_ready_next = 1'b1;
      end
    endcase
  end

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_rdata       = r_resp_rdata;
  assign resp_err         = r_resp_err;
  assign bus_en           = r_bus_en;
  assign bus_write_enable = r_bus_we;
  assign bus_byte_select  = r_bus_bs;
  assign bus_byte_enable  = r_bus_be;
  assign bus_addr         = r_bus_addr;
  assign bus_data_out     = r_bus_dout;

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: directed scenarios plus randomized
// transactions compared against a cycle-count/arithmetic reference model.
module tb_bus_master;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, req_write = 1'b0, req_byte = 1'b0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic        bus_en, bus_write_enable, bus_byte_select, bus_byte_enable;
  logic [15:0] bus_addr, bus_data_out;
  logic [15:0] bus_data_in = 16'h0;
  logic        bus_serviced_read = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations gathered by do_txn; each test compares them itself.
  int          obs_en_cnt, obs_issue_cyc, obs_resp_cyc, obs_resp_cnt, obs_ready_busy;
  logic        obs_we, obs_be, obs_bs, obs_err, obs_ready_after, obs_err_hold;
  logic [15:0] obs_addr, obs_dout, obs_rdata, obs_rdata_hold, obs_addr_at_resp;

  bus_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_en(bus_en), .bus_write_enable(bus_write_enable), .bus_byte_select(bus_byte_select),
    .bus_byte_enable(bus_byte_enable), .bus_addr(bus_addr), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_serviced_read(bus_serviced_read)
  );

  always #5 clk = ~clk;

  // Runs one transaction starting just after a rising edge; svc is the cycle
  // (relative to acceptance edge 0) in which serviced_read pulses, 0 = never.
  task automatic do_txn(input logic wr, input logic byt, input logic [15:0] addr,
                        input logic [15:0] wdata, input int svc, input logic [15:0] din);
    obs_en_cnt = 0; obs_issue_cyc = -1; obs_resp_cyc = -1; obs_resp_cnt = 0;
    obs_ready_busy = 0; obs_ready_after = 1'b0;
    req = 1'b1; req_write = wr; req_byte = byt; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      bus_serviced_read = (c == svc);
      bus_data_in = din;
      @(negedge clk);
      if (bus_en) begin
        obs_en_cnt++; obs_issue_cyc = c;
        obs_we = bus_write_enable; obs_be = bus_byte_enable; obs_bs = bus_byte_select;
        obs_addr = bus_addr; obs_dout = bus_data_out;
      end
      if (resp_valid) begin
        obs_resp_cnt++;
        if (obs_resp_cyc < 0) begin
          obs_resp_cyc = c; obs_rdata = resp_rdata; obs_err = resp_err; obs_addr_at_resp = bus_addr;
        end
      end
      if (obs_resp_cyc < 0 && req_ready) obs_ready_busy++;
      if (obs_resp_cyc >= 0 && c == obs_resp_cyc + 1) begin
        obs_ready_after = req_ready; obs_rdata_hold = resp_rdata; obs_err_hold = resp_err;
      end
      @(posedge clk); #1;
      if (obs_resp_cyc >= 0 && c == obs_resp_cyc + 1) break;
    end
    bus_serviced_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; req_write = 1'b1; req_addr = 16'hFFFF; req_wdata = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if ({resp_valid, resp_err, bus_en, bus_write_enable, bus_byte_select, bus_byte_enable} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000",
        {resp_valid, resp_err, bus_en, bus_write_enable, bus_byte_select, bus_byte_enable}); end
    n_cmp++; if ({resp_rdata, bus_addr, bus_data_out} !== 48'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {resp_rdata, bus_addr, bus_data_out}); end
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
  endtask

  task automatic test_word_write();
    do_txn(1'b1, 1'b0, 16'hFF00, 16'h00A5, 0, 16'h0);
    $display("txn word_write addr=ff00 resp_cyc=%0d", obs_resp_cyc);
    n_cmp++; if (obs_en_cnt !== 1 || obs_issue_cyc !== 1) begin n_bad++; $display("FAIL ww_issue: got cnt=%0d cyc=%0d want 1/1", obs_en_cnt, obs_issue_cyc); end
    n_cmp++; if ({obs_we, obs_bs, obs_be} !== 3'b100) begin n_bad++; $display("FAIL ww_ctrl: got %b want 100", {obs_we, obs_bs, obs_be}); end
    n_cmp++; if (obs_addr !== 16'h7F80) begin n_bad++; $display("FAIL ww_addr: got %h want 7f80", obs_addr); end
    n_cmp++; if (obs_dout !== 16'h00A5) begin n_bad++; $display("FAIL ww_data: got %h want 00a5", obs_dout); end
    n_cmp++; if (obs_resp_cyc !== 2 || obs_err !== 1'b0 || obs_rdata !== 16'h0) begin
      n_bad++; $display("FAIL ww_resp: got cyc=%0d err=%b rd=%h want 2/0/0000", obs_resp_cyc, obs_err, obs_rdata); end
  endtask

  task automatic test_byte_read();
    do_txn(1'b0, 1'b1, 16'hFF03, 16'h0, 2, 16'hAB12);
    $display("txn byte_read addr=ff03 resp_cyc=%0d rdata=%h", obs_resp_cyc, obs_rdata);
    n_cmp++; if (obs_addr !== 16'h7F81 || obs_bs !== 1'b1 || obs_be !== 1'b1 || obs_we !== 1'b0) begin
      n_bad++; $display("FAIL br_issue: got addr=%h bs=%b be=%b we=%b want 7f81/1/1/0", obs_addr, obs_bs, obs_be, obs_we); end
    n_cmp++; if (obs_resp_cyc !== 3) begin n_bad++; $display("FAIL br_latency: got %0d want 3", obs_resp_cyc); end
    n_cmp++; if (obs_rdata !== 16'h0012 || obs_err !== 1'b0) begin n_bad++; $display("FAIL br_data: got %h err=%b want 0012/0", obs_rdata, obs_err); end
    n_cmp++; if (obs_rdata_hold !== 16'h0012) begin n_bad++; $display("FAIL br_hold: got %h want 0012", obs_rdata_hold); end
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 1'b0, 16'h1234, 16'h0, 0, 16'hBEEF);
    $display("txn timeout addr=1234 resp_cyc=%0d err=%b", obs_resp_cyc, obs_err);
    n_cmp++; if (obs_resp_cyc !== 2 + TIMEOUT) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", obs_resp_cyc, 2 + TIMEOUT); end
    n_cmp++; if (obs_rdata !== 16'h0 || obs_err !== 1'b1) begin n_bad++; $display("FAIL to_resp: got %h err=%b want 0000/1", obs_rdata, obs_err); end
    n_cmp++; if (obs_ready_after !== 1'b1 || obs_err_hold !== 1'b1) begin
      n_bad++; $display("FAIL to_after: got ready=%b err=%b want 1/1", obs_ready_after, obs_err_hold); end
    // Last serviced cycle still wins; a pulse during ISSUE is stale and must time out.
    do_txn(1'b0, 1'b0, 16'h2000, 16'h0, TIMEOUT + 1, 16'h5A5A);
    $display("txn late_service resp_cyc=%0d rdata=%h", obs_resp_cyc, obs_rdata);
    n_cmp++; if (obs_resp_cyc !== TIMEOUT + 2 || obs_err !== 1'b0 || obs_rdata !== 16'h5A5A) begin
      n_bad++; $display("FAIL to_edge: got cyc=%0d err=%b rd=%h want %0d/0/5a5a", obs_resp_cyc, obs_err, obs_rdata, TIMEOUT + 2); end
    do_txn(1'b0, 1'b0, 16'h2002, 16'h0, 1, 16'h7777);
    $display("txn stale_service resp_cyc=%0d err=%b", obs_resp_cyc, obs_err);
    n_cmp++; if (obs_resp_cyc !== TIMEOUT + 2 || obs_err !== 1'b1) begin
      n_bad++; $display("FAIL stale_ignored: got cyc=%0d err=%b want %0d/1", obs_resp_cyc, obs_err, TIMEOUT + 2); end
  endtask

  task automatic test_reset_mid();
    int resp_seen;
    resp_seen = 0;
    req = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h4444;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; bus_serviced_read = 1'b1; bus_data_in = 16'hFFFF;
    @(negedge clk);
    if (resp_valid) resp_seen++;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %b want 1", req_ready); end
    n_cmp++; if ({resp_err, bus_en, bus_write_enable, bus_byte_select, bus_byte_enable} !== 5'b0 || {resp_rdata, bus_addr, bus_data_out} !== 48'h0) begin
      n_bad++; $display("FAIL rm_outputs: got err=%b en=%b rd=%h addr=%h want zeros", resp_err, bus_en, resp_rdata, bus_addr); end
    @(posedge clk); #1; bus_serviced_read = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
      @(posedge clk); #1;
    end
    $display("txn reset_mid resp_pulses=%0d", resp_seen);
    n_cmp++; if (resp_seen !== 0) begin n_bad++; $display("FAIL rm_no_resp: got %0d pulses want 0", resp_seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ready_mask, en_mask, resp_mask;
    logic [15:0] dout4, addr4;
    logic be4, we4, bs4;
    ready_mask = 8'h0; en_mask = 8'h0; resp_mask = 8'h0;
    dout4 = 16'h0; addr4 = 16'h0; be4 = 1'b0; we4 = 1'b0; bs4 = 1'b0;
    req = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0100; req_wdata = 16'h1111;
    @(posedge clk); #1;
    req_byte = 1'b1; req_addr = 16'h0203; req_wdata = 16'h003C;
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) req = 1'b0;
      @(negedge clk);
      ready_mask[c] = req_ready; en_mask[c] = bus_en; resp_mask[c] = resp_valid;
      if (c == 4) begin dout4 = bus_data_out; addr4 = bus_addr; be4 = bus_byte_enable; we4 = bus_write_enable; bs4 = bus_byte_select; end
      @(posedge clk); #1;
    end
    $display("txn back_to_back ready=%b en=%b resp=%b", ready_mask, en_mask, resp_mask);
    n_cmp++; if (ready_mask !== 8'h48) begin n_bad++; $display("FAIL b2b_ready: got %b want 01001000", ready_mask); end
    n_cmp++; if (en_mask !== 8'h12) begin n_bad++; $display("FAIL b2b_issue: got %b want 00010010", en_mask); end
    n_cmp++; if (resp_mask !== 8'h24) begin n_bad++; $display("FAIL b2b_resp: got %b want 00100100", resp_mask); end
    n_cmp++; if (dout4 !== 16'h3C3C || be4 !== 1'b1 || we4 !== 1'b1 || bs4 !== 1'b1 || addr4 !== 16'h0101) begin
      n_bad++; $display("FAIL b2b_byte: got d=%h be=%b we=%b bs=%b a=%h want 3c3c/1/1/1/0101", dout4, be4, we4, bs4, addr4); end
  endtask

  task automatic test_random();
    logic wr, byt;
    logic [15:0] addr, wdata, din, e_addr, e_dout, e_rdata;
    int svc, e_cyc;
    logic e_err;
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(0, 1)); byt = 1'($urandom_range(0, 1));
      addr = 16'($urandom); wdata = 16'($urandom); din = 16'($urandom);
      svc = $urandom_range(0, TIMEOUT + 3);
      e_addr = addr / 2;
      e_dout = byt ? 16'((wdata % 256) * 257) : wdata;
      if (wr) begin e_cyc = 2; e_rdata = 16'h0; e_err = 1'b0; end
      else if (svc >= 2 && svc <= TIMEOUT + 1) begin e_cyc = svc + 1; e_rdata = byt ? din % 256 : din; e_err = 1'b0; end
      else begin e_cyc = 2 + TIMEOUT; e_rdata = 16'h0; e_err = 1'b1; end
      do_txn(wr, byt, addr, wdata, svc, din);
      $display("txn rnd%0d wr=%b byte=%b addr=%h svc=%0d resp_cyc=%0d rdata=%h err=%b",
               t, wr, byt, addr, svc, obs_resp_cyc, obs_rdata, obs_err);
      n_cmp++; if (obs_en_cnt !== 1 || obs_issue_cyc !== 1) begin n_bad++; $display("FAIL rnd_issue t=%0d: got cnt=%0d cyc=%0d want 1/1", t, obs_en_cnt, obs_issue_cyc); end
      n_cmp++; if ({obs_we, obs_be, obs_bs} !== {wr, byt, addr[0]}) begin n_bad++; $display("FAIL rnd_ctrl t=%0d: got %b want %b", t, {obs_we, obs_be, obs_bs}, {wr, byt, addr[0]}); end
      n_cmp++; if (obs_addr !== e_addr || obs_dout !== e_dout) begin n_bad++; $display("FAIL rnd_bus t=%0d: got %h/%h want %h/%h", t, obs_addr, obs_dout, e_addr, e_dout); end
      n_cmp++; if (obs_resp_cyc !== e_cyc || obs_resp_cnt !== 1) begin n_bad++; $display("FAIL rnd_latency t=%0d: got cyc=%0d n=%0d want %0d/1", t, obs_resp_cyc, obs_resp_cnt, e_cyc); end
      n_cmp++; if (obs_rdata !== e_rdata || obs_err !== e_err) begin n_bad++; $display("FAIL rnd_resp t=%0d: got %h/%b want %h/%b", t, obs_rdata, obs_err, e_rdata, e_err); end
      n_cmp++; if (obs_rdata_hold !== e_rdata || obs_err_hold !== e_err || obs_addr_at_resp !== e_addr) begin
        n_bad++; $display("FAIL rnd_hold t=%0d: got %h/%b/%h want %h/%b/%h", t, obs_rdata_hold, obs_err_hold, obs_addr_at_resp, e_rdata, e_err, e_addr); end
      n_cmp++; if (obs_ready_busy !== 0 || obs_ready_after !== 1'b1) begin n_bad++; $display("FAIL rnd_ready t=%0d: got busy=%0d after=%b want 0/1", t, obs_ready_busy, obs_ready_after); end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, read-wait cycles before abort (range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  in  1  CPU request valid.
REQ-005 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-006 SHALL have port req_byte  in  1  1 = byte access, 0 = word access.
REQ-007 SHALL have port req_addr  in  16  CPU byte address.
REQ-008 SHALL have port req_wdata  in  16  store data.
REQ-009 SHALL have port req_ready  out  1  high only in IDLE; a request is accepted when req & req_ready.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  out  16  load result, valid with resp_valid.
REQ-012 SHALL have port resp_err  out  1  read timeout flag, valid with resp_valid.
REQ-013 SHALL have ports bus_en, bus_write_enable, bus_byte_select, bus_byte_enable  out  1 each  bus controls to memory/MMIO responders.
REQ-014 SHALL have ports bus_addr  out  16  word address; bus_data_out  out  16  write data.
REQ-015 SHALL have ports bus_data_in  in  16  and bus_serviced_read  in  1  responder read data and read-complete strobe.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-017 IDLE: on req high, SHALL latch request fields and go to ISSUE; otherwise stay.
REQ-018 ISSUE (exactly one cycle): bus_en=1; bus_write_enable=req_write; bus_byte_enable=req_byte; bus_addr={1'b0, req_addr[15:1]}; bus_byte_select=req_addr[0].
REQ-019 ISSUE write data: bus_data_out = req_byte ? {wdata[7:0], wdata[7:0]} : wdata.
REQ-020 ISSUE -> RESP for writes (no wait), ISSUE -> WAIT for reads.
REQ-021 Outside ISSUE, bus_en, bus_write_enable, bus_byte_enable and bus_byte_select SHALL be 0; bus_addr and bus_data_out hold their last value.
REQ-022 bus_serviced_read sampled during ISSUE SHALL be ignored (stale).
REQ-023 WAIT: wait counter (8 bit) SHALL be 0 on entry and increment each WAIT cycle without bus_serviced_read.
REQ-024 WAIT with bus_serviced_read=1 SHALL capture data: word -> bus_data_in; byte -> {8'h00, bus_data_in[7:0]}; err=0; go RESP.
REQ-025 WAIT with counter == TIMEOUT-1 and no bus_serviced_read SHALL set rdata=0, err=1, go RESP; serviced_read and timeout in the same cycle -> serviced wins.
REQ-026 RESP (exactly one cycle): resp_valid=1; go IDLE. Writes SHALL report rdata=0, err=0.
REQ-027 Latency: accept at edge 0 -> write resp_valid in cycle 2; read resp_valid earliest in cycle 3; timeout resp_valid in cycle 2+TIMEOUT.
REQ-028 No pipelining: req_ready SHALL be low in ISSUE/WAIT/RESP; a req held high is accepted again only after returning to IDLE (back-to-back throughput 3 cycles for writes).
REQ-029 resp_rdata and resp_err SHALL hold their value until the next RESP.

Reset
REQ-030 While rst=1 (sampled on clk): state=IDLE, counter=0; all outputs SHALL be 0 except req_ready=1.
REQ-031 Reset mid-operation SHALL abandon the transaction with no resp_valid; a bus_serviced_read arriving afterwards SHALL be ignored.

Verification
REQ-032 Word write 0x00A5 to 0xFF00: 1-cycle bus_en, write_enable=1, bus_addr=0x7F80, byte_select=0, data 0x00A5; resp_valid cycle 2, err 0.
REQ-033 Byte read 0xFF03; responder returns serviced_read 1 cycle after ISSUE with data 0xAB12: bus_addr=0x7F81, byte_select=1; resp_rdata=0x0012, err 0, resp_valid cycle 3.
REQ-034 Word read 0x1234, no serviced_read, TIMEOUT=15: resp_valid cycle 17, rdata=0x0000, err=1; then back in IDLE.
REQ-035 rst asserted during WAIT, serviced_read pulsed next cycle: no resp_valid; outputs at reset values; req_ready=1.
REQ-036 req held high for two writes: req_ready low cycles 1-2; second ISSUE in cycle 4; byte write 0x3C -> bus_data_out=0x3C3C, byte_enable=1.
